// File: rtl/powersaver_pkg.sv
// Shared state encoding and parameter defaults for the stopwatch display power-saver.
package powersaver_pkg;

   typedef enum logic [1:0] {
      ACTIVE = 2'b00,
      ARMED  = 2'b01,
      WARN   = 2'b10,
      SLEEP  = 2'b11
   } ps_state_t;

   localparam int WARN_CYCLES_DEF = 8;
   localparam int BLINK_DIV_DEF   = 4;

endpackage

// File: rtl/powersaver_ctrl_edge_detect.sv
// Rising-edge detector: registers d and flags the cycle where it goes 0 -> 1.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) d_q <= 1'b0;
      else       d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/powersaver_ctrl.sv
// Display power-saver: blinks the display while paused at the idle mark, then sleeps it.
// Optional build macro POWERSAVER_AUTOWAKE_EN: a falling edge of pause also leaves SLEEP.
//
// state  | meaning
// ACTIVE | display on, not paused
// ARMED  | paused, waiting for the idle mark
// WARN   | blinking the display, warn timer running
// SLEEP  | display off, counter held
module powersaver_ctrl
   import powersaver_pkg::*;
#(
   parameter int WARN_CYCLES = WARN_CYCLES_DEF,
   parameter int BLINK_DIV   = BLINK_DIV_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       signalpowersaver,
   input  logic       pause,
   input  logic       wake,
   output logic       display_en,
   output logic       blink,
   output logic       sleep,
   output logic       count_hold,
   output logic [1:0] state
);

   localparam int TW = $clog2(WARN_CYCLES);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(WARN_CYCLES - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

   ps_state_t     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic          wake_rise;
   logic          leave_sleep;

   edge_detect u_wake_edge (
      .clk   (clk),
      .reset (reset),
      .d     (wake),
      .rise  (wake_rise)
   );

`ifdef POWERSAVER_AUTOWAKE_EN
   logic pause_fall;

   // Rise of ~pause is a fall of pause; its reset value only matters outside SLEEP.
   edge_detect u_pause_edge (
      .clk   (clk),
      .reset (reset),
      .d     (~pause),
      .rise  (pause_fall)
   );

   assign leave_sleep = wake_rise | pause_fall;
`else
   assign leave_sleep = wake_rise;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ACTIVE;
         timer_q <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
      end
   end

   // Timer and blink state default to cleared, so any entry into WARN starts fresh.
   always_comb begin
      state_d = state_q;
      timer_d = '0;
      bcnt_d  = '0;
      phase_d = 1'b0;
      if (wake_rise) begin
         state_d = ACTIVE;
      end else begin
         case (state_q)
            ACTIVE: begin
               if (pause) state_d = ARMED;
            end
            ARMED: begin
               if (!pause)                state_d = ACTIVE;
               else if (signalpowersaver) state_d = WARN;
            end
            WARN: begin
               if (!pause) begin
                  state_d = ACTIVE;
               end else if (timer_q == T_LAST) begin
                  state_d = SLEEP;
               end else begin
                  timer_d = timer_q + 1'b1;
                  if (bcnt_q == B_LAST) begin
                     bcnt_d  = '0;
                     phase_d = ~phase_q;
                  end else begin
                     bcnt_d  = bcnt_q + 1'b1;
                     phase_d = phase_q;
                  end
               end
            end
            SLEEP: begin
               if (leave_sleep) state_d = ACTIVE;
            end
            default: state_d = ACTIVE;
         endcase
      end
   end

   always_comb begin
      display_en = 1'b1;
      blink      = 1'b0;
      sleep      = 1'b0;
      count_hold = 1'b0;
      case (state_q)
         WARN: begin
            blink      = phase_q;
            display_en = ~phase_q;
         end
         SLEEP: begin
            display_en = 1'b0;
            sleep      = 1'b1;
            count_hold = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: doc/powersaver_ctrl.md
Name: powersaver_ctrl

Overview:
- Downstream consumer of the seconds-stage idle flag `signalpowersaver` in the stopwatch.
- Watches that flag together with `pause`. When the watch has sat paused at the idle mark, it warns by blinking the display, then puts the display to sleep.
- On wake it restores the display.
- It also drives `count_hold`; the integrator ORs this into the counter stage's pause input while asleep.

Parameters:
- WARN_CYCLES, default 8: clock cycles spent in WARN before SLEEP. Must be >= 2.
- BLINK_DIV, default 4: cycles per blink phase in WARN. Must be >= 1.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- signalpowersaver, input, 1: level from the counter stage; high while count == 5'b11110.
- pause, input, 1: stopwatch pause level, synchronous to clk.
- wake, input, 1: wake button level, already synchronised to clk.
- display_en, output, 1: 1 = display driven.
- blink, output, 1: current blink phase, high only in WARN.
- sleep, output, 1: high in SLEEP.
- count_hold, output, 1: high in SLEEP.
- state, output, 2: current state encoding, for debug.

Behaviour:
- States and encodings: ACTIVE = 2'b00, ARMED = 2'b01, WARN = 2'b10, SLEEP = 2'b11.
- Reset (asynchronous, effective immediately, including mid-WARN or mid-SLEEP):
  - state = ACTIVE; warn timer = 0; blink counter = 0; blink phase = 0; wake_q = 0.
  - Outputs: display_en = 1, blink = 0, sleep = 0, count_hold = 0.
- Wake edge detection:
  - wake_q is the registered copy of wake.
  - wake_rise = wake & ~wake_q.
  - A held wake produces exactly one wake_rise.
- Transitions are evaluated at a clk edge, with wake_rise at highest priority:
  - ACTIVE: pause = 1 -> ARMED; otherwise stay.
  - ARMED: pause = 0 -> ACTIVE. Else signalpowersaver = 1 -> WARN. Else stay.
  - WARN:
    - wake_rise or pause = 0 -> ACTIVE.
    - Else timer == WARN_CYCLES-1 -> SLEEP.
    - Else timer increments.
  - SLEEP: wake_rise -> ACTIVE. pause and signalpowersaver are ignored.
- Simultaneous events:
  - wake_rise in the same cycle as WARN timer expiry -> ACTIVE, not SLEEP.
  - In ARMED, pause falling together with signalpowersaver high -> ACTIVE.
- Timers:
  - Warn timer is $clog2(WARN_CYCLES) bits wide.
  - Cleared on every entry to WARN and whenever not in WARN; never wraps.
  - WARN lasts exactly WARN_CYCLES cycles when undisturbed.
- Blink:
  - Counter is $clog2(BLINK_DIV) bits wide (1 bit minimum), active only in WARN.
  - Phase toggles when the counter == BLINK_DIV-1, then the counter wraps to 0.
  - Counter and phase are cleared on entry to WARN, so the first phase is 0.
- Outputs are Moore, decoded from registered state and phase. They change in the cycle after the causing input is sampled.
  - ACTIVE and ARMED: display_en = 1, blink = 0.
  - WARN: blink = phase, display_en = ~phase.
  - SLEEP: display_en = 0, sleep = 1, count_hold = 1.
  - sleep and count_hold are 0 in every state except SLEEP.

Optional Feature:
- Macro: POWERSAVER_AUTOWAKE_EN.
- Defined: in SLEEP, a falling edge of pause (registered pause_q = 1, pause = 0) also returns to ACTIVE, with the same timing as wake_rise.
- Not defined: only wake_rise leaves SLEEP; pause_q is not instantiated.

Decomposition:
- Package powersaver_pkg holds:
  - typedef enum logic [1:0] ps_state_t (ACTIVE, ARMED, WARN, SLEEP);
  - localparam defaults for WARN_CYCLES and BLINK_DIV.
- One sub-module, edge_detect: clk, reset, d -> rise. It is reused for wake, and for pause when POWERSAVER_AUTOWAKE_EN is defined.

Test Plan (WARN_CYCLES = 8, BLINK_DIV = 4):
- Reset asserted mid-WARN -> state = 00, display_en = 1, blink = 0, sleep = 0 in the same cycle, before any clk edge.
- pause = 1, then signalpowersaver = 1 held -> ARMED after 1 cycle, WARN after 1 more, SLEEP after exactly 8 WARN cycles.
  - During WARN, blink reads 0,0,0,0,1,1,1,1.
  - In SLEEP, count_hold = 1 and display_en = 0.
- In SLEEP, pulse wake high for 3 cycles -> ACTIVE after 1 cycle, display_en = 1; no second transition while wake stays high.
- wake_rise in the 8th WARN cycle, simultaneous with expiry -> ACTIVE; sleep never asserts.
- In WARN cycle 3, drop pause -> ACTIVE next cycle, timer cleared. Re-pausing with signalpowersaver = 1 restarts the full 8-cycle WARN.
- In SLEEP, pause 1 -> 0:
  - with POWERSAVER_AUTOWAKE_EN -> ACTIVE;
  - without -> stays SLEEP until wake_rise.
